wb_ctrl: RTL and testbench



---
 rtl/wb_ctrl_pkg.sv | 19 +
 rtl/wb_ctrl_if.sv | 27 ++
 rtl/wb_ctrl.sv | 100 ++++++++++
 tb/tb_wb_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared writeback definitions: source-select codes and sequencer states.
package wb_defs;

  localparam logic [2:0] WB_BTR   = 3'd0;
  localparam logic [2:0] WB_SET_T = 3'd1;
  localparam logic [2:0] WB_SET_F = 3'd2;
  localparam logic [2:0] WB_LINK  = 3'd3;
  localparam logic [2:0] WB_LBI   = 3'd4;
  localparam logic [2:0] WB_SLBI  = 3'd5;
  localparam logic [2:0] WB_ALU   = 3'd6;
  localparam logic [2:0] WB_MEM   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_ctrl_if.sv
// Memory-stage to writeback handshake bundle for wb_ctrl.
interface wb_ctrl_if;

  logic       InstValid;
  logic       MemRead;
  logic       RegWrite;
  logic [2:0] WrReg;
  logic [2:0] OutSel;
  logic       MemDone;
  logic       MemErr;
  logic       Stall;
  logic       WrEn;
  logic [2:0] WrRegOut;
  logic [2:0] WbSel;
  logic       Err;

  modport master (
    output InstValid, MemRead, RegWrite, WrReg, OutSel, MemDone, MemErr,
    input  Stall, WrEn, WrRegOut, WbSel, Err
  );

  modport slave (
    input  InstValid, MemRead, RegWrite, WrReg, OutSel, MemDone, MemErr,
    output Stall, WrEn, WrRegOut, WbSel, Err
  );

endinterface

// File: rtl/wb_ctrl.sv
// Writeback sequencer: one-cycle writeback for non-loads, stall-and-wait for
// loads with a bounded wait and a sticky error state.
module wb_ctrl
  import wb_defs::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_ctrl_if.slave bus
);

  wb_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_cap_we;
  logic [2:0]       r_cap_reg;
  logic             r_wr_en, w_wr_en;
  logic [2:0]       r_wr_reg, w_wr_reg;
  logic [2:0]       r_wb_sel, w_wb_sel;
  logic             w_accept_load;
  logic             w_timeout;

  assign w_accept_load = (r_state == IDLE) & bus.InstValid & bus.MemRead;
  assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cap_we  <= 1'b0;
      r_cap_reg <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wb_sel  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wr_en  <= w_wr_en;
      r_wr_reg <= w_wr_reg;
      r_wb_sel <= w_wb_sel;
      if (w_accept_load) begin
        r_cap_we  <= bus.RegWrite;
        r_cap_reg <= bus.WrReg;
      end
    end
  end

  // Exit priority in WAIT: fault, then completion, then timeout.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept_load) w_state_nxt = WAIT;
      WAIT: begin
        if (bus.MemErr)       w_state_nxt = ERR;
        else if (bus.MemDone) w_state_nxt = IDLE;
        else if (w_timeout)   w_state_nxt = ERR;
      end
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_reg  = r_wr_reg;
    w_wb_sel  = r_wb_sel;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.InstValid) begin
          if (bus.MemRead) begin
            w_cnt_nxt = '0;
          end else begin
            w_wr_en  = bus.RegWrite;
            w_wr_reg = bus.WrReg;
            w_wb_sel = bus.OutSel;
          end
        end
      end
      WAIT: begin
        if (!bus.MemErr && bus.MemDone) begin
          w_wr_en  = r_cap_we;
          w_wr_reg = r_cap_reg;
          w_wb_sel = WB_MEM;
        end else if (!bus.MemDone) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.Stall    = (r_state == WAIT) | (r_state == ERR);
  assign bus.Err      = (r_state == ERR);
  assign bus.WrEn     = r_wr_en;
  assign bus.WrRegOut = r_wr_reg;
  assign bus.WbSel    = r_wb_sel;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level model.
module tb_wb_ctrl;

  localparam int unsigned TIMEOUT = 15;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  wb_ctrl_if u_if ();

  wb_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       iv, mr, rw;
    logic [2:0] wr, os;
    logic       dn, me;
    logic       e_we;
    logic [2:0] e_reg, e_sel;
    logic       e_st, e_er;
  } vec_t;

  vec_t vt[15];

  // model state: pending load, waited cycles, sticky error, expected outputs
  bit         m_pend, m_err;
  int         m_wait;
  logic       m_cwe;
  logic [2:0] m_creg;
  logic       m_we;
  logic [2:0] m_reg, m_sel;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [2:0] rg,
                         input logic [2:0] sl, input logic st, input logic er);
    chk({tag, ".WrEn"},     {7'd0, u_if.WrEn},     {7'd0, we});
    chk({tag, ".WrRegOut"}, {5'd0, u_if.WrRegOut}, {5'd0, rg});
    chk({tag, ".WbSel"},    {5'd0, u_if.WbSel},    {5'd0, sl});
    chk({tag, ".Stall"},    {7'd0, u_if.Stall},    {7'd0, st});
    chk({tag, ".Err"},      {7'd0, u_if.Err},      {7'd0, er});
  endtask

  task automatic drive(input logic iv, input logic mr, input logic rw, input logic [2:0] wr,
                       input logic [2:0] os, input logic dn, input logic me);
    u_if.InstValid = iv;
    u_if.MemRead   = mr;
    u_if.RegWrite  = rw;
    u_if.WrReg     = wr;
    u_if.OutSel    = os;
    u_if.MemDone   = dn;
    u_if.MemErr    = me;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_err = 0; m_wait = 0;
    m_cwe = 1'b0; m_creg = 3'd0;
    m_we = 1'b0; m_reg = 3'd0; m_sel = 3'd0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Expected result of the coming edge, from the current inputs.
  task automatic model_step();
    m_we = 1'b0;
    if (m_err) begin
      // stuck until reset
    end else if (m_pend) begin
      if (u_if.MemErr) begin
        m_err = 1; m_pend = 0;
      end else if (u_if.MemDone) begin
        m_we = m_cwe; m_reg = m_creg; m_sel = 3'd7; m_pend = 0;
      end else if (m_wait + 1 >= int'(TIMEOUT)) begin
        m_err = 1; m_pend = 0;
      end else begin
        m_wait++;
      end
    end else if (u_if.InstValid) begin
      if (u_if.MemRead) begin
        m_pend = 1; m_wait = 0; m_cwe = u_if.RegWrite; m_creg = u_if.WrReg;
      end else begin
        m_we = u_if.RegWrite; m_reg = u_if.WrReg; m_sel = u_if.OutSel;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    //         iv    mr    rw    wr    os    dn    me    we    reg   sel   st    er
    vt[0]  = '{1'b1, 1'b0, 1'b1, 3'd3, 3'd6, 1'b0, 1'b0, 1'b1, 3'd3, 3'd6, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 3'd5, 3'd1, 1'b0, 1'b0, 1'b1, 3'd5, 3'd1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd4, 1'b0, 1'b0, 1'b0, 3'd5, 3'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 3'd4, 3'd2, 1'b0, 1'b0, 1'b0, 3'd4, 3'd2, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd2, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 3'd7, 3'd6, 1'b0, 1'b0, 1'b0, 3'd4, 3'd2, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 3'd7, 3'd6, 1'b0, 1'b0, 1'b0, 3'd4, 3'd2, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 3'd7, 3'd6, 1'b1, 1'b0, 1'b1, 3'd2, 3'd7, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 3'd7, 3'd6, 1'b0, 1'b0, 1'b1, 3'd7, 3'd6, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 3'd7, 3'd6, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd6, 3'd7, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd6, 3'd7, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd6, 3'd7, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd6, 3'd7, 1'b1, 1'b1};
    vt[14] = '{1'b1, 1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 3'd6, 3'd7, 1'b1, 1'b1};

    apply_reset();
    chk_all("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].iv, vt[i].mr, vt[i].rw, vt[i].wr, vt[i].os, vt[i].dn, vt[i].me);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_reg, vt[i].e_sel, vt[i].e_st, vt[i].e_er);
    end

    // Timeout: accept at cycle 0, Err appears at cycle TIMEOUT+1.
    apply_reset();
    drive(1'b1, 1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
    step();
    chk_all("to.c1", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    for (int c = 2; c <= int'(TIMEOUT) + 1; c++) begin
      step();
      chk($sformatf("to.c%0d.Stall", c), {7'd0, u_if.Stall}, 8'd1);
      chk($sformatf("to.c%0d.Err", c), {7'd0, u_if.Err}, (c >= int'(TIMEOUT) + 1) ? 8'd1 : 8'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    step();
    chk_all("to.late_done", 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);

    // Asynchronous reset two cycles into WAIT.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 3'd2, 3'd5, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    chk_all("mid.wait", 1'b0, 3'd2, 3'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("mid.rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 3'd4, 3'd3, 1'b1, 1'b0);
    step();
    chk_all("mid.after", 1'b1, 3'd4, 3'd3, 1'b0, 1'b0);

    // Randomized traffic against the model, with occasional async resets.
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all($sformatf("rnd%0d.rst", n), 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
            3'($urandom), 3'($urandom_range(0, 6)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      model_step();
      step();
      chk_all($sformatf("rnd%0d", n), m_we, m_reg, m_sel, m_pend || m_err, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
